// File: rtl/rv32i_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_stage_if
// Bundles every non-clock/reset signal of the fetch stage.
//   redirect_valid / redirect_pc      : redirect from branch/jump resolution
//   imem_req_valid/ready/addr         : instruction-memory request channel
//   imem_rsp_valid/data               : in-order instruction-memory responses
//   id_valid/ready, id_pc, id_instr   : fetch -> decode channel
// Modports:
//   master : the fetch stage itself
//   slave  : its environment (memory, decode, redirect source)
// ---------------------------------------------------------------------------
interface rv32i_fetch_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr
  );
endinterface

// File: rtl/rv32i_fetch_stage.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_stage
// Instruction-fetch front end of the RV32I pipeline. Owns the PC, issues
// word fetches to instruction memory, buffers returned words in a small
// queue and presents {pc, instr} to decode. A redirect flushes the queue,
// retargets the PC and marks every still-in-flight response for discard.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : rv32i_fetch_stage_if.master (redirect, imem req/rsp, decode)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never waits on ready. The decode head stays stable while
// id_valid && !id_ready. Memory responses carry no ready: they are always
// accepted, arrive in request order, and never in the accepting cycle.
// ---------------------------------------------------------------------------
module rv32i_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          CNT_W       = 2
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_fetch_stage_if.master bus
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int OW = AW + 1;
  // Wide enough for outstanding + occupancy without overflow.
  localparam int SW = ((CNT_W > OW) ? CNT_W : OW) + 1;

  logic [31:0]      pc_q, pc_d;
  // PC of the next response that will be kept. Kept responses are always
  // consecutive words starting at the last redirect/reset target, so this
  // replaces a per-request PC FIFO.
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]    cnt_q, cnt_d;

  logic [31:0]      q_pc_mem    [QUEUE_DEPTH];
  logic [31:0]      q_instr_mem [QUEUE_DEPTH];

  logic             redirect, rsp, nonempty;
  logic             accept, pop, push;
  logic [SW-1:0]    credit;
  logic [31:0]      redirect_tgt;

  assign redirect     = bus.redirect_valid;
  assign rsp          = bus.imem_rsp_valid;
  assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
  assign nonempty     = (cnt_q != '0);

  assign bus.id_valid = nonempty && !redirect && !rst;
  assign pop          = bus.id_valid && bus.id_ready;

  // Every accepted request already owns a queue slot; a same-cycle pop
  // frees one, which keeps 1 instr/cycle with a 2-entry queue.
  assign credit             = SW'(out_q) + SW'(cnt_q) - SW'(pop);
  assign bus.imem_req_valid = !rst && !redirect && (credit < SW'(QUEUE_DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;

  // Responses in the redirect cycle, or owed to an older redirect, are dropped.
  assign push = rsp && (drop_q == '0) && !redirect;

  assign bus.id_pc    = nonempty ? q_pc_mem[rd_q]    : 32'h0;
  assign bus.id_instr = nonempty ? q_instr_mem[rd_q] : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CNT_W'(accept) - CNT_W'(rsp);
    drop_d   = drop_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    if (redirect) begin
      pc_d     = redirect_tgt;
      rsp_pc_d = redirect_tgt;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d   = out_d;
      wr_d     = '0;
      rd_d     = '0;
      cnt_d    = '0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (rsp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (push) begin
        wr_d     = wr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      assert (!(rsp && (out_q == '0)));
      assert (!(push && (cnt_q == OW'(QUEUE_DEPTH))));
    end
  end

  // Queue storage needs no reset: the read side is gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc_mem[wr_q]    <= rsp_pc_q;
      q_instr_mem[wr_q] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
module tb_rv32i_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_fetch_stage_if bus ();

  rv32i_fetch_stage #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH),
    .CNT_W       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard and reference model
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];          // {pc, instr} decode must still see, in order
  logic [31:0] mem_addr_q[$];     // addresses the memory owes a response for
  logic [31:0] mem_pc_q[$];       // model PC of those requests
  int          mem_due_q[$];
  int          mem_ep_q[$];       // path generation the request belongs to
  int          epoch = 0;
  int          cyc   = 0;
  int          lat   = 1;
  bit          gaps  = 1'b0;
  logic [31:0] exp_pc;

  // observations of the last cycle, for the directed steps
  logic        last_req_valid, last_idv;
  logic [31:0] last_addr, last_id_pc;
  logic [31:0] acc_log[$];
  int          first_acc, first_idv, pop_cnt;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model at the edge,
  // then drive the memory response for the new cycle.
  task automatic cycle();
    logic        exp_idv, exp_rv, acc, pop, rspv, redir, rs;
    logic [31:0] addr, rpc, p;
    int          inflight, e;
    @(negedge clk);
    rs       = rst;
    redir    = bus.redirect_valid;
    rpc      = bus.redirect_pc;
    exp_idv  = !rs && !redir && (exp_q.size() > 0);
    inflight = mem_addr_q.size() + exp_q.size() - ((exp_idv && bus.id_ready) ? 1 : 0);
    exp_rv   = !rs && !redir && (inflight < DEPTH);
    chk("id_valid", 32'(bus.id_valid), 32'(exp_idv));
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_idv && bus.id_valid) begin
      chk("id_pc", bus.id_pc, exp_q[0][63:32]);
      chk("id_instr", bus.id_instr, exp_q[0][31:0]);
    end
    if (exp_rv && bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_pc);
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    pop  = bus.id_valid && bus.id_ready;
    rspv = bus.imem_rsp_valid;
    addr = bus.imem_req_addr;
    last_req_valid = bus.imem_req_valid;
    last_idv       = bus.id_valid;
    last_addr      = addr;
    last_id_pc     = bus.id_pc;
    if (acc) acc_log.push_back(addr);
    if (acc && first_acc < 0) first_acc = cyc;
    if (bus.id_valid && first_idv < 0) first_idv = cyc;
    if (pop) pop_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      exp_q.delete();
      mem_addr_q.delete(); mem_pc_q.delete(); mem_due_q.delete(); mem_ep_q.delete();
      exp_pc = RESET_PC;
      epoch++;
    end else begin
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (rspv && mem_addr_q.size() > 0) begin
        void'(mem_addr_q.pop_front());
        p = mem_pc_q.pop_front();
        void'(mem_due_q.pop_front());
        e = mem_ep_q.pop_front();
        if (!redir && e == epoch) exp_q.push_back({p, instr_of(p)});
      end
      if (acc) begin
        mem_addr_q.push_back(addr);
        mem_pc_q.push_back(exp_pc);
        mem_due_q.push_back(cyc + lat - 1);
        mem_ep_q.push_back(epoch);
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
        epoch++;
        exp_q.delete();
        exp_pc = {rpc[31:2], 2'b00};
      end
    end
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && (!gaps || $urandom_range(0, 3) != 0)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mem_addr_q[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  initial begin
    bit got;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    exp_pc             = RESET_PC;
    first_acc = -1; first_idv = -1; pop_cnt = 0;

    // reset
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_req_addr", bus.imem_req_addr, RESET_PC);

    // streaming with 1-cycle memory
    first_acc = -1; first_idv = -1; pop_cnt = 0; acc_log.delete();
    repeat (10) cycle();
    chk("first_idv_latency", 32'(first_idv - first_acc), 32'd2);
    chk("stream_pops", 32'(pop_cnt), 32'd8);
    for (int i = 0; i < 4; i++) chk("stream_addr", acc_log[i], RESET_PC + 32'(4 * i));

    // decode stall: queue fills, requests stop
    bus.id_ready = 1'b0;
    repeat (5) cycle();
    chk("stall_req_valid", 32'(last_req_valid), 32'd0);
    chk("stall_id_valid", 32'(last_idv), 32'd1);
    bus.id_ready = 1'b1;
    repeat (6) cycle();

    // memory back-pressure: address holds
    bus.imem_req_ready = 1'b0;
    repeat (3) cycle();
    chk("hold_req_valid", 32'(last_req_valid), 32'd1);
    chk("hold_addr", last_addr, exp_pc);
    bus.imem_req_ready = 1'b1;
    acc_log.delete();
    p_resume: begin
      logic [31:0] held;
      held = last_addr;
      repeat (4) cycle();
      chk("resume_addr", acc_log[0], held);
    end

    // 3-cycle memory, redirect with two requests in flight
    lat = 3;
    repeat (4) cycle();
    for (int i = 0; i < 20 && mem_addr_q.size() != 2; i++) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("redir_no_req", 32'(last_req_valid), 32'd0);
    chk("redir_no_idv", 32'(last_idv), 32'd0);
    acc_log.delete();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (last_idv) got = 1'b1;
    end
    chk("redir_timeout", 32'(got), 32'd1);
    chk("redir_first_id_pc", last_id_pc, 32'h0000_0100);
    chk("redir_first_req", acc_log[0], 32'h0000_0100);

    // redirect colliding with a response and a ready decode
    lat = 1;
    repeat (6) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("coll_idv_redirect", 32'(last_idv), 32'd0);
    cycle();
    chk("coll_idv_next", 32'(last_idv), 32'd0);
    repeat (6) cycle();

    // PC wrap, then reset mid-stream
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    cycle();
    bus.redirect_valid = 1'b0;
    acc_log.delete();
    repeat (6) cycle();
    chk("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", acc_log[2], 32'h0000_0000);
    rst = 1'b1;
    repeat (2) cycle();
    chk("midrst_idv", 32'(last_idv), 32'd0);
    chk("midrst_req_valid", 32'(last_req_valid), 32'd0);
    rst = 1'b0;
    acc_log.delete();
    repeat (5) cycle();
    chk("post_rst_addr", acc_log[0], RESET_PC);

    // randomized traffic against the model
    gaps = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 3);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc    = $urandom;
      rst                = ($urandom_range(0, 149) == 0);
      cycle();
    end
    bus.redirect_valid = 1'b0;
    rst                = 1'b0;
    bus.id_ready       = 1'b1;
    bus.imem_req_ready = 1'b1;
    gaps               = 1'b0;
    repeat (12) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
